// File: rtl/ccd_linear_timing.sv
// ccd_linear_timing: linear CCD sequencer producing phi/sh/rs/sp drive signals and a pixel strobe.
// Optional macro CCD_INTEG_EXT_EN adds the INTEG state (int_ext extra phi periods between frames).
module ccd_linear_timing #(
    parameter int HALF   = 50,
    parameter int NCYC   = 2720,
    parameter int SH_CYC = 1,
    parameter int DUMMY  = 3,
    parameter int RS_ON  = 25,
    parameter int RS_OFF = 40,
    parameter int SP_ON  = 10,
    parameter int SP_OFF = 23,
    localparam int IW    = $clog2(2 * NCYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic [15:0]   int_ext,
    output logic          phi,
    output logic          sh,
    output logic          rs,
    output logic          sp,
    output logic          pix_valid,
    output logic [IW-1:0] pix_idx,
    output logic          busy,
    output logic          done
);
    localparam int HW = $clog2(HALF);
    localparam int PW = $clog2(NCYC);

    localparam logic [HW-1:0] HC_LAST  = HW'(HALF - 1);
    localparam logic [HW-1:0] RS_ON_C  = HW'(RS_ON);
    localparam logic [HW-1:0] RS_OFF_C = HW'(RS_OFF);
    localparam logic [HW-1:0] SP_ON_C  = HW'(SP_ON);
    localparam logic [HW-1:0] SP_OFF_C = HW'(SP_OFF);
    localparam logic [PW-1:0] SH_LAST  = PW'(SH_CYC - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(NCYC - 1);
    localparam logic [PW-1:0] DUMMY_C  = PW'(DUMMY);

`ifdef CCD_INTEG_EXT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, READ, INTEG} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, READ} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hc;
    logic          ph;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_rel;
    logic          end_period;
    logic          frame_end;
    logic          sp_win;

`ifdef CCD_INTEG_EXT_EN
    logic [15:0]   gc;
    logic [15:0]   int_cap;
`else
    logic          unused_int_ext;
    assign unused_int_ext = ^int_ext;
`endif

    // A phi period ends on the last cycle of its high half.
    assign end_period = (hc == HC_LAST) && ph;
    assign sp_win     = (state == READ) && (pc >= DUMMY_C);
    assign pc_rel     = pc - DUMMY_C;
    assign busy       = (state != IDLE);
    assign done       = frame_end && !rst;

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SHIFT;
            SHIFT: if (end_period && pc == SH_LAST) state_next = READ;
            READ: begin
                if (end_period && pc == PC_LAST) begin
                    frame_end = 1'b1;
                    if (!cont)
                        state_next = IDLE;
`ifdef CCD_INTEG_EXT_EN
                    else if (int_ext != 16'd0)
                        state_next = INTEG;
`endif
                    else
                        state_next = SHIFT;
                end
            end
`ifdef CCD_INTEG_EXT_EN
            INTEG: if (end_period && gc == int_cap - 16'd1) state_next = SHIFT;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hc        <= '0;
            ph        <= 1'b0;
            pc        <= '0;
            phi       <= 1'b0;
            sh        <= 1'b0;
            rs        <= 1'b0;
            sp        <= 1'b0;
            pix_valid <= 1'b0;
            pix_idx   <= '0;
        end else begin
            state <= state_next;

            if (state == IDLE) begin
                hc <= '0;
                ph <= 1'b0;
            end else if (hc == HC_LAST) begin
                hc <= '0;
                ph <= ~ph;
            end else begin
                hc <= hc + 1'b1;
            end

            // pc is cleared at every frame boundary so each SHIFT begins at period 0.
            if (state == IDLE || frame_end)
                pc <= '0;
            else if (end_period && (state == SHIFT || state == READ))
                pc <= pc + 1'b1;

            // sh is derived from the next state so it spans exactly the SHIFT periods.
            sh        <= (state_next == SHIFT);
            phi       <= (state_next != IDLE) && (ph || sh);
            rs        <= (state != IDLE) && (hc >= RS_ON_C) && (hc < RS_OFF_C);
            sp        <= sp_win && (hc >= SP_ON_C) && (hc < SP_OFF_C);
            pix_valid <= sp_win && (hc == SP_OFF_C);
            if (sp_win && hc == SP_OFF_C)
                pix_idx <= {pc_rel, ph};
        end
    end

`ifdef CCD_INTEG_EXT_EN
    // The gap length is latched at READ exit so int_ext may change during INTEG.
    always_ff @(posedge clk) begin
        if (rst) begin
            gc      <= '0;
            int_cap <= '0;
        end else if (frame_end) begin
            gc      <= '0;
            int_cap <= int_ext;
        end else if (state == INTEG && end_period) begin
            gc <= gc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccd_linear_timing.sv
// tb_ccd_linear_timing: scoreboard bench for ccd_linear_timing with a small frame geometry.
module tb_ccd_linear_timing;
    localparam int H     = 8;
    localparam int N     = 10;
    localparam int D     = 3;
    localparam int S     = 1;
    localparam int RSON  = 2;
    localparam int RSOFF = 5;
    localparam int SPON  = 1;
    localparam int SPOFF = 4;
    localparam int F     = N * 2 * H;
    localparam int IW    = $clog2(2 * N);
`ifdef CCD_INTEG_EXT_EN
    localparam int EXP_GAP = 3 * 2 * H;
    localparam int EXP_RS  = 6;
`else
    localparam int EXP_GAP = 0;
    localparam int EXP_RS  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic [15:0]   int_ext;
    logic          phi, sh, rs, sp, pix_valid, busy, done;
    logic [IW-1:0] pix_idx;

    int nCompared   = 0;
    int nMismatched = 0;
    int expQ[$];

    ccd_linear_timing #(
        .HALF(H), .NCYC(N), .SH_CYC(S), .DUMMY(D),
        .RS_ON(RSON), .RS_OFF(RSOFF), .SP_ON(SPON), .SP_OFF(SPOFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .int_ext(int_ext),
        .phi(phi), .sh(sh), .rs(rs), .sp(sp), .pix_valid(pix_valid),
        .pix_idx(pix_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pushFrame();
        for (int i = 0; i < 2 * (N - D); i++) expQ.push_back(i);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_sh"}, sh, 0);
        checkOutput({tag, "_phi"}, phi, 0);
        checkOutput({tag, "_rs"}, rs, 0);
        checkOutput({tag, "_sp"}, sp, 0);
        checkOutput({tag, "_pv"}, pix_valid, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // k is the cycle index within the frame; outputs reflect counters of cycle k-1.
    task automatic checkCycle(input int k, input bit prevCont);
        int kp, hcp, php, perp;
        int eSh, ePhi, eRs, eSp, ePv;
        kp   = k - 1;
        hcp  = (k > 0) ? kp % H : 0;
        php  = (k > 0) ? (kp / H) % 2 : 0;
        perp = (k > 0) ? kp / (2 * H) : 0;
        eSh  = (k < S * 2 * H) ? 1 : 0;
        ePhi = (k == 0) ? int'(prevCont) : ((php == 1 || kp < S * 2 * H) ? 1 : 0);
        eRs  = (k > 0 && hcp >= RSON && hcp < RSOFF) ? 1 : 0;
        eSp  = (k > 0 && perp >= D && hcp >= SPON && hcp < SPOFF) ? 1 : 0;
        ePv  = (k > 0 && perp >= D && hcp == SPOFF) ? 1 : 0;
        checkOutput($sformatf("sh@%0d", k), sh, eSh);
        checkOutput($sformatf("phi@%0d", k), phi, ePhi);
        checkOutput($sformatf("rs@%0d", k), rs, eRs);
        checkOutput($sformatf("sp@%0d", k), sp, eSp);
        checkOutput($sformatf("pv@%0d", k), pix_valid, ePv);
        checkOutput($sformatf("busy@%0d", k), busy, 1);
        checkOutput($sformatf("done@%0d", k), done, (k == F - 1) ? 1 : 0);
        if (pix_valid) begin
            if (expQ.size() == 0)
                checkOutput($sformatf("pix_extra@%0d", k), 1, 0);
            else
                checkOutput($sformatf("pix_idx@%0d", k), pix_idx, expQ.pop_front());
        end
    endtask

    task automatic checkFrame(input bit nowFirst, input bit prevCont, input bit keepStart,
                              input bit contEnd, input bit startAtDone, input int abortK);
        for (int k = 0; k < F; k++) begin
            if (!(k == 0 && nowFirst)) @(negedge clk);
            if (k == 0 && !keepStart) start = 1'b0;
            checkCycle(k, prevCont);
            if (k == abortK) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdle("abort");
                checkOutput("abort_pix_idx", pix_idx, 0);
                expQ.delete();
                return;
            end
            if (startAtDone && k == F - 1) start = 1'b1;
        end
        checkOutput("pix_left", expQ.size(), 0);
        if (!contEnd) begin
            @(negedge clk);
            if (startAtDone) start = 1'b0;
            checkIdle("end");
            if (startAtDone) begin
                @(negedge clk);
                checkIdle("nodup");
            end
        end
    endtask

    task automatic applyStimulus(input bit keepStart, input bit contEnd,
                                 input bit startAtDone, input int abortK);
        pushFrame();
        @(negedge clk);
        start = 1'b1;
        checkFrame(1'b0, 1'b0, keepStart, contEnd, startAtDone, abortK);
    endtask

    initial begin
        int g, rsRises, spHigh, doneSeen;
        bit found, prevRs;
        rst = 1'b1; start = 1'b0; cont = 1'b0; int_ext = 16'd0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        checkOutput("reset_pix_idx", pix_idx, 0);
        rst = 1'b0;

        // Single-shot frame, then a start pulse coinciding with done.
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 1'b1, -1);

        // start held through a frame: exactly one new frame per IDLE entry.
        applyStimulus(1'b1, 1'b0, 1'b0, -1);
        pushFrame();
        checkFrame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Continuous mode with an integration gap; int_ext changed mid-gap.
        cont = 1'b1;
        int_ext = 16'd3;
        applyStimulus(1'b0, 1'b1, 1'b0, -1);
        g = 0; rsRises = 0; spHigh = 0; found = 1'b0; prevRs = rs;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sh) begin
                found = 1'b1;
                break;
            end
            g++;
            if (rs && !prevRs) rsRises++;
            prevRs = rs;
            if (sp) spHigh++;
            if (!busy) checkOutput("gap_busy", busy, 1);
            if (i == 5) int_ext = 16'd7;
        end
        checkOutput("gap_found", found, 1);
        checkOutput("gap_len", g, EXP_GAP);
        checkOutput("gap_rs_pulses", rsRises, EXP_RS);
        checkOutput("gap_sp", spHigh, 0);
        cont = 1'b0;
        pushFrame();
        checkFrame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        // Reset mid-READ at pc=5, then no done afterwards.
        applyStimulus(1'b0, 1'b0, 1'b0, 5 * 2 * H + 5);
        doneSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("abort_quiet", doneSeen, 0);

        // rst wins over start in the same cycle.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_prio_busy", busy, 0);
        @(negedge clk);
        checkOutput("rst_prio_busy2", busy, 0);

        // Clean frame after the abort.
        applyStimulus(1'b0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
